// File: rtl/mux_arb_n.sv
// N-input, W-bit selector with a registered valid/ready output stage.
// The grant comes from an explicit select, fixed priority or round-robin.
module mux_arb_n #(
  parameter int W    = 5,
  parameter int N    = 4,
  parameter int MODE = 0,
  parameter int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          load;
  logic          sel_vld, pri_vld, rr_vld;
  logic [SW-1:0] sel_gnt, pri_gnt, rr_gnt;
  logic          gnt_vld_p0;
  logic [SW-1:0] gnt_p0;
  logic [SW-1:0] ptr;
  logic [W-1:0]  data_p1;
  logic [SW-1:0] src_p1;
  logic          vld_p1;

  assign load = !vld_p1 || out_ready;

  // Explicit select: an out-of-range sel matches no channel.
  always_comb begin
    sel_vld = 1'b0;
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) begin
        sel_vld = 1'b1;
        sel_gnt = SW'(i);
      end
    end
  end

  always_comb begin
    pri_vld = 1'b0;
    pri_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        pri_vld = 1'b1;
        pri_gnt = SW'(i);
      end
    end
  end

  // Round-robin: search from ptr+1 upward modulo N; later loop passes win,
  // so the k=1 candidate (just after the last grant) has highest priority.
  always_comb begin
    rr_vld = 1'b0;
    rr_gnt = '0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (i == (int'(ptr) + k) % N && in_valid[i]) begin
          rr_vld = 1'b1;
          rr_gnt = SW'(i);
        end
      end
    end
  end

  always_comb begin
    case (MODE)
      0:       begin gnt_vld_p0 = sel_vld; gnt_p0 = sel_gnt; end
      1:       begin gnt_vld_p0 = pri_vld; gnt_p0 = pri_gnt; end
      default: begin gnt_vld_p0 = rr_vld;  gnt_p0 = rr_gnt;  end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && gnt_vld_p0 && (gnt_p0 == SW'(i));
    end
  end

  // p0 -> p1: output register, loaded on transfer, drained when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr     <= SW'(N - 1);
    end else if (load) begin
      if (gnt_vld_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data[int'(gnt_p0)*W +: W];
        src_p1  <= gnt_p0;
        if (MODE == 2) ptr <= gnt_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_src   = src_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: four instances (2:1 select, 3-way select, priority,
// round-robin) checked against directed tables and a behavioural model.
module tb_mux_arb_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] dat  [4][4];
  logic [3:0] vld  [4];
  logic [1:0] sl   [4];
  logic       ordy [4];

  logic [1:0] rdy0; logic [4:0] od0; logic [0:0] os0; logic ov0;
  logic [2:0] rdy1; logic [4:0] od1; logic [1:0] os1; logic ov1;
  logic [3:0] rdy2; logic [4:0] od2; logic [1:0] os2; logic ov2;
  logic [3:0] rdy3; logic [4:0] od3; logic [1:0] os3; logic ov3;

  mux_arb_n #(.W(5), .N(2), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data({dat[0][1], dat[0][0]}), .in_valid(vld[0][1:0]),
    .in_ready(rdy0), .sel(sl[0][0]), .out_data(od0), .out_src(os0),
    .out_valid(ov0), .out_ready(ordy[0]));
  mux_arb_n #(.W(5), .N(3), .MODE(0)) u1 (
    .clk(clk), .rst(rst), .in_data({dat[1][2], dat[1][1], dat[1][0]}), .in_valid(vld[1][2:0]),
    .in_ready(rdy1), .sel(sl[1]), .out_data(od1), .out_src(os1),
    .out_valid(ov1), .out_ready(ordy[1]));
  mux_arb_n #(.W(5), .N(4), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_data({dat[2][3], dat[2][2], dat[2][1], dat[2][0]}), .in_valid(vld[2]),
    .in_ready(rdy2), .sel(sl[2]), .out_data(od2), .out_src(os2),
    .out_valid(ov2), .out_ready(ordy[2]));
  mux_arb_n #(.W(5), .N(4), .MODE(2)) u3 (
    .clk(clk), .rst(rst), .in_data({dat[3][3], dat[3][2], dat[3][1], dat[3][0]}), .in_valid(vld[3]),
    .in_ready(rdy3), .sel(sl[3]), .out_data(od3), .out_src(os3),
    .out_valid(ov3), .out_ready(ordy[3]));

  localparam int NN [4] = '{2, 3, 4, 4};
  localparam int MM [4] = '{0, 0, 1, 2};

  int nchk = 0;
  int nerr = 0;

  // Reference model state: last-granted index and output register contents.
  int m_ptr [4];
  bit m_ov  [4];
  int m_od  [4];
  int m_os  [4];
  int cap_rdy [4];

  function automatic int get_rdy(int k);
    case (k)
      0: return int'(rdy0);
      1: return int'(rdy1);
      2: return int'(rdy2);
      default: return int'(rdy3);
    endcase
  endfunction

  function automatic int get_ov(int k);
    case (k)
      0: return int'(ov0);
      1: return int'(ov1);
      2: return int'(ov2);
      default: return int'(ov3);
    endcase
  endfunction

  function automatic int get_od(int k);
    case (k)
      0: return int'(od0);
      1: return int'(od1);
      2: return int'(od2);
      default: return int'(od3);
    endcase
  endfunction

  function automatic int get_os(int k);
    case (k)
      0: return int'(os0);
      1: return int'(os1);
      2: return int'(os2);
      default: return int'(os3);
    endcase
  endfunction

  // Winner from the selection rules; -1 when no channel is granted.
  function automatic int mgrant(int k);
    int n, s;
    n = NN[k];
    s = (n == 2) ? int'(sl[k][0]) : int'(sl[k]);
    if (MM[k] == 0) begin
      if (s < n && vld[k][s]) return s;
      return -1;
    end else if (MM[k] == 1) begin
      for (int i = 0; i < n; i++) if (vld[k][i]) return i;
      return -1;
    end
    for (int j = 1; j <= n; j++) begin
      if (vld[k][(m_ptr[k] + j) % n]) return (m_ptr[k] + j) % n;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ptr[k] = NN[k] - 1;
      m_ov[k]  = 1'b0;
      m_od[k]  = 0;
      m_os[k]  = 0;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs.
  task automatic step();
    int ga [4];
    bit la [4];
    #1;
    for (int k = 0; k < 4; k++) begin
      ga[k] = mgrant(k);
      la[k] = !m_ov[k] || ordy[k];
      cap_rdy[k] = get_rdy(k);
      chk($sformatf("in_ready[u%0d]", k), cap_rdy[k], (la[k] && ga[k] >= 0) ? (1 << ga[k]) : 0);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (la[k]) begin
          if (ga[k] >= 0) begin
            m_ov[k] = 1'b1;
            m_od[k] = int'(dat[k][ga[k]]);
            m_os[k] = ga[k];
            if (MM[k] == 2) m_ptr[k] = ga[k];
          end else begin
            m_ov[k] = 1'b0;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[u%0d]", k), get_ov(k), int'(m_ov[k]));
      chk($sformatf("out_data[u%0d]", k), get_od(k), m_od[k]);
      chk($sformatf("out_src[u%0d]", k), get_os(k), m_os[k]);
    end
  endtask

  task automatic quiet();
    for (int k = 0; k < 4; k++) begin
      vld[k]  = 4'b0000;
      sl[k]   = 2'd0;
      ordy[k] = 1'b1;
    end
  endtask

  typedef struct {
    int         inst;
    logic [3:0] v;
    logic [1:0] s;
    bit         r;
    int         erdy;
    int         eov;
    int         esrc;
    int         edat;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(int inst, logic [3:0] v, logic [1:0] s, bit r,
                              int erdy, int eov, int esrc, int edat);
    vec_t e;
    e.inst = inst; e.v = v; e.s = s; e.r = r;
    e.erdy = erdy; e.eov = eov; e.esrc = esrc; e.edat = edat;
    return e;
  endfunction

  task automatic run_vec(input vec_t e, input int idx);
    quiet();
    vld[e.inst]  = e.v;
    sl[e.inst]   = e.s;
    ordy[e.inst] = e.r;
    step();
    chk($sformatf("tbl%0d.ready", idx), cap_rdy[e.inst], e.erdy);
    chk($sformatf("tbl%0d.valid", idx), get_ov(e.inst), e.eov);
    chk($sformatf("tbl%0d.src", idx), get_os(e.inst), e.esrc);
    chk($sformatf("tbl%0d.data", idx), get_od(e.inst), e.edat);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) dat[k][i] = 5'(k * 8 + i + 1);
    dat[0][0] = 5'd3;
    dat[0][1] = 5'd17;
    quiet();
    model_reset();
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset.valid[u%0d]", k), get_ov(k), 0);
      chk($sformatf("reset.data[u%0d]", k), get_od(k), 0);
    end

    // 2:1 legacy select, out-of-range select, priority
    tbl.push_back(mk(0, 4'b0011, 2'd0, 1'b1, 'b01,   1, 0, 3));
    tbl.push_back(mk(0, 4'b0011, 2'd1, 1'b1, 'b10,   1, 1, 17));
    tbl.push_back(mk(0, 4'b0000, 2'd0, 1'b1, 'b00,   0, 1, 17));
    tbl.push_back(mk(1, 4'b0111, 2'd2, 1'b1, 'b100,  1, 2, 11));
    tbl.push_back(mk(1, 4'b0111, 2'd3, 1'b1, 'b000,  0, 2, 11));
    tbl.push_back(mk(2, 4'b1010, 2'd0, 1'b1, 'b0010, 1, 1, 18));
    tbl.push_back(mk(2, 4'b1000, 2'd0, 1'b1, 'b1000, 1, 3, 20));
    // Round-robin rotation from reset, then a lone requester
    for (int r = 0; r < 8; r++)
      tbl.push_back(mk(3, 4'b1111, 2'd0, 1'b1, 1 << (r % 4), 1, r % 4, 25 + r % 4));
    tbl.push_back(mk(3, 4'b0100, 2'd0, 1'b1, 'b0100, 1, 2, 27));
    tbl.push_back(mk(3, 4'b0100, 2'd0, 1'b1, 'b0100, 1, 2, 27));
    // Stall three cycles, then release: grant follows the pre-stall ptr
    for (int r = 0; r < 3; r++)
      tbl.push_back(mk(3, 4'b1111, 2'd0, 1'b0, 'b0000, 1, 2, 27));
    tbl.push_back(mk(3, 4'b1111, 2'd0, 1'b1, 'b1000, 1, 3, 28));
    tbl.push_back(mk(3, 4'b1111, 2'd0, 1'b1, 'b0001, 1, 0, 25));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset mid-stream with a transfer offered; ptr must return to N-1
    quiet();
    vld[3] = 4'b1111;
    rst = 1'b1;
    step();
    chk("midrst.valid", get_ov(3), 0);
    chk("midrst.src", get_os(3), 0);
    rst = 1'b0;
    step();
    chk("postrst.ready", cap_rdy[3], 1);
    chk("postrst.src", get_os(3), 0);
    chk("postrst.data", get_od(3), 25);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 4; k++) begin
        vld[k]  = 4'($urandom);
        sl[k]   = 2'($urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0)
          for (int i = 0; i < 4; i++) dat[k][i] = 5'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
